// File: rtl/bus_console_pkg.sv
// Shared FSM state type, register offsets and status word layout
// for the bus console slave and its per-channel byte FIFOs.
package bus_console_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_ERROR = 3'd3,
    ST_END   = 3'd4
  } state_t;

  localparam logic [8:0] DATA_OFS = 9'h000;
  localparam logic [8:0] STAT_OFS = 9'h100;

  localparam int STAT_FULL_BIT = 0;
  localparam int STAT_LVL_LSB  = 8;

  function automatic logic [31:0] stat_word(
    input logic [7:0] lvl,
    input logic       full
  );
    logic [31:0] w;
    w = '0;
    w[STAT_LVL_LSB +: 8] = lvl;
    w[STAT_FULL_BIT]     = full;
    return w;
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Byte FIFO for one console channel. Ports: push_i/din_i write,
// pop_i read, dout_o head byte, level_o count 0..DEPTH, full_o, empty_o.
module console_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [7:0]    din_i,
  input  logic          pop_i,
  output logic [7:0]    dout_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (level_o == LW'(DEPTH));
  assign empty_o = (level_o == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_o <= level_o + LW'(1);
        2'b01:   level_o <= level_o - LW'(1);
        default: level_o <= level_o;
      endcase
    end
  end

  // Storage needs no reset: reads are gated by the level.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din_i;
  end

endmodule

// File: rtl/bus_console_slave.sv
// Bus slave exposing NUM_CH console channels: write-only data regs push
// bytes into per-channel FIFOs, read-only status regs report level/full.
// Ports: bus_* master/slave handshake, char_* round-robin output stream.
module bus_console_slave
  import bus_console_pkg::*;
#(
  parameter  logic [31:0] BASE_ADDR  = 32'h6000_0000,
  parameter  int          NUM_CH     = 4,
  parameter  int          FIFO_DEPTH = 16,
  localparam int          CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int          LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [31:0]   bus_addrData_i,
  input  logic [3:0]    bus_byteEnables_i,
  input  logic [7:0]    bus_burstSize_i,
  input  logic          bus_readNWrite_i,
  input  logic          bus_beginTransaction_i,
  input  logic          bus_endTransaction_i,
  input  logic          bus_dataValid_i,
  output logic [31:0]   bus_addrData_o,
  output logic          bus_endTransaction_o,
  output logic          bus_dataValid_o,
  output logic          bus_busy_o,
  output logic          bus_error_o,
  output logic [7:0]    char_o,
  output logic [CW-1:0] char_ch_o,
  output logic          char_valid_o,
  input  logic          char_ready_i
);

  state_t        state;
  logic [CW-1:0] ch_q;
  logic          err_rd;

  logic [8:0]    ofs;
  logic          sel;
  logic          aligned;
  logic          ch_ok;
  logic          is_data;
  logic          is_stat;
  logic          wr_ok;
  logic          rd_ok;

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [7:0]        dout  [NUM_CH];
  logic [LW-1:0]     level [NUM_CH];

  logic [7:0]    wbyte;
  logic          beat_ok;

  logic [CW-1:0] rr;
  logic [CW-1:0] pick;
  logic [CW-1:0] hold_ch;
  logic [CW-1:0] sel_ch;
  logic          hold;
  logic          found;

  assign ofs     = bus_addrData_i[8:0];
  assign sel     = bus_beginTransaction_i &&
                   (bus_addrData_i[31:9] == BASE_ADDR[31:9]);
  assign aligned = (ofs[1:0] == 2'b00);
  assign ch_ok   = ({1'b0, ofs[7:2]} < 7'(NUM_CH));
  assign is_data = (ofs[8] == DATA_OFS[8]);
  assign is_stat = (ofs[8] == STAT_OFS[8]);
  assign wr_ok   = aligned && ch_ok && is_data;
  assign rd_ok   = aligned && ch_ok && is_stat &&
                   (bus_burstSize_i == 8'd0);

  // Busy looks at the registered level only, so a same-cycle pop
  // never makes room for a push.
  assign bus_busy_o = (state == ST_WRITE) && full[ch_q];
  assign beat_ok    = (state == ST_WRITE) && bus_dataValid_i &&
                      !bus_busy_o && (bus_byteEnables_i != 4'h0);

  always_comb begin
    wbyte = bus_addrData_i[7:0];
    if (bus_byteEnables_i[0])      wbyte = bus_addrData_i[7:0];
    else if (bus_byteEnables_i[1]) wbyte = bus_addrData_i[15:8];
    else if (bus_byteEnables_i[2]) wbyte = bus_addrData_i[23:16];
    else                           wbyte = bus_addrData_i[31:24];
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign push[c] = beat_ok && (ch_q == CW'(c));
    assign pop[c]  = char_valid_o && char_ready_i &&
                     (sel_ch == CW'(c));
    console_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push[c]),
      .din_i   (wbyte),
      .pop_i   (pop[c]),
      .dout_o  (dout[c]),
      .level_o (level[c]),
      .full_o  (full[c]),
      .empty_o (empty[c])
    );
  end

  // rr names the first channel to consider; search wraps from there.
  always_comb begin
    int j;
    j     = 0;
    pick  = rr;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      j = int'(rr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!found && !empty[j]) begin
        found = 1'b1;
        pick  = CW'(j);
      end
    end
  end

  // A stalled offer stays locked so a newer byte on a higher-priority
  // channel cannot swap the presented character.
  assign sel_ch       = hold ? hold_ch : pick;
  assign char_valid_o = found;
  assign char_o       = found ? dout[sel_ch] : 8'h00;
  assign char_ch_o    = found ? sel_ch : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr      <= '0;
      hold    <= 1'b0;
      hold_ch <= '0;
    end else begin
      hold    <= char_valid_o && !char_ready_i;
      hold_ch <= sel_ch;
      if (char_valid_o && char_ready_i) begin
        rr <= (sel_ch == CW'(NUM_CH - 1)) ? '0 : sel_ch + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ST_IDLE;
      ch_q   <= '0;
      err_rd <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (sel) begin
            ch_q   <= ofs[2 +: CW];
            err_rd <= bus_readNWrite_i;
            if (bus_readNWrite_i)
              state <= rd_ok ? ST_READ : ST_ERROR;
            else
              state <= wr_ok ? ST_WRITE : ST_ERROR;
          end
        end
        ST_WRITE: begin
          if (bus_endTransaction_i && !bus_busy_o) state <= ST_IDLE;
        end
        ST_READ:  state <= ST_END;
        ST_END:   state <= ST_IDLE;
        ST_ERROR: begin
          if (err_rd || bus_endTransaction_i) state <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign bus_dataValid_o      = (state == ST_READ);
  assign bus_addrData_o       = bus_dataValid_o ?
                                stat_word(8'(level[ch_q]), full[ch_q]) :
                                32'h0;
  assign bus_endTransaction_o = (state == ST_END) ||
                                ((state == ST_ERROR) && err_rd);
  assign bus_error_o          = (state == ST_ERROR);

endmodule

// File: tb/tb_bus_console_slave.sv
// Directed bench for bus_console_slave: writes, bursts with backpressure,
// round-robin order, status reads, error cases and mid-burst reset.
module tb_bus_console_slave;

  localparam logic [31:0] BASE = 32'h6000_0000;

  logic        clk;
  logic        rst_ni;
  logic [31:0] bus_addrData_i;
  logic [3:0]  bus_byteEnables_i;
  logic [7:0]  bus_burstSize_i;
  logic        bus_readNWrite_i;
  logic        bus_beginTransaction_i;
  logic        bus_endTransaction_i;
  logic        bus_dataValid_i;
  logic [31:0] bus_addrData_o;
  logic        bus_endTransaction_o;
  logic        bus_dataValid_o;
  logic        bus_busy_o;
  logic        bus_error_o;
  logic [7:0]  char_o;
  logic [1:0]  char_ch_o;
  logic        char_valid_o;
  logic        char_ready_i;

  bus_console_slave u_dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_ni),
    .bus_addrData_i         (bus_addrData_i),
    .bus_byteEnables_i      (bus_byteEnables_i),
    .bus_burstSize_i        (bus_burstSize_i),
    .bus_readNWrite_i       (bus_readNWrite_i),
    .bus_beginTransaction_i (bus_beginTransaction_i),
    .bus_endTransaction_i   (bus_endTransaction_i),
    .bus_dataValid_i        (bus_dataValid_i),
    .bus_addrData_o         (bus_addrData_o),
    .bus_endTransaction_o   (bus_endTransaction_o),
    .bus_dataValid_o        (bus_dataValid_o),
    .bus_busy_o             (bus_busy_o),
    .bus_error_o            (bus_error_o),
    .char_o                 (char_o),
    .char_ch_o              (char_ch_o),
    .char_valid_o           (char_valid_o),
    .char_ready_i           (char_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Every accepted character as {channel, byte}; the next posedge pops it.
  logic [15:0] cap [$];
  always @(negedge clk) begin
    #1;
    if (char_valid_o && char_ready_i)
      cap.push_back({6'h0, char_ch_o, char_o});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus_addrData_i         = '0;
    bus_byteEnables_i      = '0;
    bus_burstSize_i        = '0;
    bus_readNWrite_i       = 1'b0;
    bus_beginTransaction_i = 1'b0;
    bus_endTransaction_i   = 1'b0;
    bus_dataValid_i        = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle_inputs();
    cyc(2);
    rst_ni = 1'b1;
    cyc(1);
    cap.delete();
  endtask

  task automatic bus_begin(input logic [31:0] a, input logic rnw,
                           input logic [7:0] bs);
    bus_beginTransaction_i = 1'b1;
    bus_addrData_i         = a;
    bus_readNWrite_i       = rnw;
    bus_burstSize_i        = bs;
    @(negedge clk);
    bus_beginTransaction_i = 1'b0;
    bus_addrData_i         = '0;
    bus_readNWrite_i       = 1'b0;
    bus_burstSize_i        = '0;
  endtask

  task automatic bus_beat(input logic [31:0] d, input logic [3:0] be,
                          output logic busy0);
    int n;
    bus_dataValid_i   = 1'b1;
    bus_addrData_i    = d;
    bus_byteEnables_i = be;
    busy0 = bus_busy_o;
    n = 0;
    while (bus_busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("beat_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bus_dataValid_i   = 1'b0;
    bus_addrData_i    = '0;
    bus_byteEnables_i = '0;
  endtask

  task automatic bus_end();
    bus_endTransaction_i = 1'b1;
    @(negedge clk);
    bus_endTransaction_i = 1'b0;
  endtask

  task automatic wr1(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be);
    logic b;
    bus_begin(a, 1'b0, 8'd0);
    bus_beat(d, be, b);
    bus_end();
  endtask

  logic [15:0] exp_q [$];
  logic        b;
  int          nbusy;
  int          n;

  initial begin
    rst_ni       = 1'b0;
    char_ready_i = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("rst_data", bus_addrData_o, 32'h0);
    chk("rst_flags", {bus_endTransaction_o, bus_dataValid_o, bus_busy_o,
                      bus_error_o, char_valid_o, char_ch_o, char_o}, 32'h0);
    rst_ni = 1'b1;
    cyc(1);

    // single byte to ch2
    char_ready_i = 1'b1;
    cap.delete();
    bus_begin(BASE + 32'h8, 1'b0, 8'd0);
    bus_dataValid_i   = 1'b1;
    bus_addrData_i    = 32'h0000_0041;
    bus_byteEnables_i = 4'b0001;
    chk("wr_not_early", char_valid_o, 1'b0);
    @(negedge clk);
    idle_inputs();
    chk("wr_visible", char_valid_o, 1'b1);
    bus_end();
    cyc(3);
    chk("wr_count", cap.size(), 1);
    if (cap.size() > 0) chk("wr_char", cap[0], 16'h0241);
    chk("wr_drained", char_valid_o, 1'b0);

    // 17-beat burst into a 16-deep FIFO with the sink stalled
    do_reset();
    char_ready_i = 1'b0;
    bus_begin(BASE, 1'b0, 8'd16);
    nbusy = 0;
    for (int i = 0; i < 16; i++) begin
      bus_beat(32'h10 + i, 4'b0001, b);
      if (b) nbusy++;
    end
    chk("burst_busy_early", nbusy, 0);
    bus_dataValid_i   = 1'b1;
    bus_addrData_i    = 32'h20;
    bus_byteEnables_i = 4'b0001;
    chk("burst_busy17", bus_busy_o, 1'b1);
    chk("hold_char_a", {char_ch_o, char_o}, 10'h010);
    cyc(3);
    chk("burst_busy_held", bus_busy_o, 1'b1);
    chk("hold_char_b", {char_ch_o, char_o}, 10'h010);
    char_ready_i = 1'b1;
    n = 0;
    while (bus_busy_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("busy_release", bus_busy_o, 1'b0);
    @(negedge clk);
    idle_inputs();
    bus_end();
    cyc(25);
    chk("burst_count", cap.size(), 17);
    for (int i = 0; i < 17; i++) begin
      if (i < cap.size()) chk("burst_order", cap[i], 16'h0010 + 16'(i));
    end

    // round-robin across channels, plus lane selection and empty beats
    do_reset();
    char_ready_i = 1'b0;
    wr1(BASE + 32'h0, 32'h0000_00A0, 4'b0001);
    wr1(BASE + 32'h4, 32'h0000_00B1, 4'b0001);
    bus_begin(BASE + 32'h8, 1'b0, 8'd1);
    bus_beat(32'hFFFF_FFFF, 4'b0000, b);
    bus_beat(32'h0000_C200, 4'b0010, b);
    bus_end();
    wr1(BASE + 32'hC, 32'h5A6B_0000, 4'b1100);
    wr1(BASE + 32'h4, 32'h0000_00B2, 4'b0001);
    char_ready_i = 1'b1;
    cyc(10);
    exp_q = '{16'h00A0, 16'h01B1, 16'h02C2, 16'h036B, 16'h01B2};
    chk("rr_count", cap.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < cap.size()) chk("rr_order", cap[i], exp_q[i]);
    end

    // status read of ch1 holding three bytes
    char_ready_i = 1'b0;
    bus_begin(BASE + 32'h4, 1'b0, 8'd2);
    for (int i = 0; i < 3; i++) bus_beat(32'h31 + i, 4'b0001, b);
    bus_end();
    bus_begin(BASE + 32'h104, 1'b1, 8'd0);
    chk("rd_dv", bus_dataValid_o, 1'b1);
    chk("rd_data", bus_addrData_o, 32'h0000_0300);
    chk("rd_end_early", bus_endTransaction_o, 1'b0);
    @(negedge clk);
    chk("rd_end", {bus_endTransaction_o, bus_dataValid_o}, 2'b10);
    chk("rd_data_off", bus_addrData_o, 32'h0);
    @(negedge clk);
    chk("rd_done", bus_endTransaction_o, 1'b0);

    // error cases and an unselected begin
    do_reset();
    char_ready_i = 1'b0;
    bus_begin(BASE + 32'h10, 1'b0, 8'd1);
    chk("werr_a", bus_error_o, 1'b1);
    bus_beat(32'h0000_0077, 4'b0001, b);
    chk("werr_b", bus_error_o, 1'b1);
    bus_beat(32'h0000_0078, 4'b0001, b);
    bus_endTransaction_i = 1'b1;
    chk("werr_c", {bus_error_o, bus_endTransaction_o}, 2'b10);
    @(negedge clk);
    bus_endTransaction_i = 1'b0;
    chk("werr_off", bus_error_o, 1'b0);
    bus_begin(BASE, 1'b1, 8'd0);
    chk("rerr", {bus_error_o, bus_endTransaction_o}, 2'b11);
    @(negedge clk);
    chk("rerr_off", {bus_error_o, bus_endTransaction_o}, 2'b00);
    bus_begin(32'h0000_0008, 1'b0, 8'd0);
    chk("unsel", {bus_error_o, bus_busy_o, bus_endTransaction_o}, 3'b000);
    bus_beat(32'h0000_0099, 4'b0001, b);
    bus_end();
    chk("err_no_fifo", char_valid_o, 1'b0);
    bus_begin(BASE + 32'h100, 1'b1, 8'd0);
    chk("err_stat0", bus_addrData_o, 32'h0);
    cyc(2);

    // reset in the middle of a burst with five bytes buffered
    do_reset();
    char_ready_i = 1'b0;
    bus_begin(BASE, 1'b0, 8'd7);
    for (int i = 0; i < 5; i++) bus_beat(32'h60 + i, 4'b0001, b);
    chk("mid_buffered", char_valid_o, 1'b1);
    bus_dataValid_i   = 1'b1;
    bus_addrData_i    = 32'h66;
    bus_byteEnables_i = 4'b0001;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_data", bus_addrData_o, 32'h0);
    chk("mid_rst_flags", {bus_endTransaction_o, bus_dataValid_o, bus_busy_o,
                          bus_error_o, char_valid_o, char_ch_o, char_o}, 32'h0);
    @(negedge clk);
    idle_inputs();
    cyc(1);
    rst_ni = 1'b1;
    char_ready_i = 1'b1;
    cap.delete();
    cyc(10);
    chk("post_rst_none", cap.size(), 0);
    chk("post_rst_valid", char_valid_o, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
